// File: rtl/ex_stage.sv
// ex_stage: execute stage of the RV32IM pipeline.
// The forwarding muxes pick operands A and B, and a single-cycle ALU/multiplier
// computes the result. DIV/DIVU/REM/REMU use a restoring divider that retires
// one bit per cycle and holds the upstream stages through stall_ex. The stage
// registers ctrl, rd, pc4, the result and the store data into EX/MEM.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   valid_ex, flush         live instruction / kill it
//   ctrl_ex, alu_op         control bits passed to MEM, operation select
//   alu_src, fwd_a, fwd_b   operand B source, forwarding selects
//   rs1_data, rs2_data, imm, rd_ex, pc4_ex, wb_data   datapath inputs
//   stall_ex                hold IF/ID/EX this cycle
//   ctrl_mem, rd_mem, pc4_mem, alu_result, write_data1   EX/MEM register
module ex_stage #(
  parameter int DIV_BITS = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_ex,
  input  logic        flush,
  input  logic [4:0]  ctrl_ex,
  input  logic [4:0]  alu_op,
  input  logic        alu_src,
  input  logic [1:0]  fwd_a,
  input  logic [1:0]  fwd_b,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  input  logic [31:0] rd_ex,
  input  logic [31:0] pc4_ex,
  input  logic [31:0] wb_data,
  output logic        stall_ex,
  output logic [4:0]  ctrl_mem,
  output logic [31:0] rd_mem,
  output logic [31:0] pc4_mem,
  output logic [31:0] alu_result,
  output logic [31:0] write_data1
);
  localparam int CW = $clog2(DIV_BITS + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  div_state_t  state;
  logic [CW-1:0] cnt;
  logic [31:0] quo, rem, dvs, a_orig;
  logic        neg_q, neg_r, by_zero, want_rem;

  // operand selection
  logic [31:0] op_a, op_bf, op_b;
  always_comb begin
    case (fwd_a)
      2'b01:   op_a = alu_result;
      2'b10:   op_a = wb_data;
      default: op_a = rs1_data;
    endcase
    case (fwd_b)
      2'b01:   op_bf = alu_result;
      2'b10:   op_bf = wb_data;
      default: op_bf = rs2_data;
    endcase
  end
  assign op_b = alu_src ? imm : op_bf;

  // One 64x64 multiplier. Each operand is sign- or zero-extended according to
  // the op, so the low 64 bits of the product are exact for all signedness
  // combinations. MUL uses the low word, and the low word does not depend on
  // the extension.
  logic        a_sx, b_sx;
  logic [63:0] prod;
  assign a_sx = ((alu_op == 5'd12) || (alu_op == 5'd13)) && op_a[31];
  assign b_sx = (alu_op == 5'd12) && op_b[31];
  assign prod = {{32{a_sx}}, op_a} * {{32{b_sx}}, op_b};

  logic [31:0] alu_comb;
  always_comb begin
    case (alu_op)
      5'd0:  alu_comb = op_a + op_b;
      5'd1:  alu_comb = op_a - op_b;
      5'd2:  alu_comb = op_a << op_b[4:0];
      5'd3:  alu_comb = {31'b0, $signed(op_a) < $signed(op_b)};
      5'd4:  alu_comb = {31'b0, op_a < op_b};
      5'd5:  alu_comb = op_a ^ op_b;
      5'd6:  alu_comb = op_a >> op_b[4:0];
      5'd7:  alu_comb = $unsigned($signed(op_a) >>> op_b[4:0]);
      5'd8:  alu_comb = op_a | op_b;
      5'd9:  alu_comb = op_a & op_b;
      5'd10: alu_comb = op_b;
      5'd11: alu_comb = prod[31:0];
      5'd12, 5'd13, 5'd14: alu_comb = prod[63:32];
      default: alu_comb = 32'h0;
    endcase
  end

  logic is_div, div_signed, a_neg, b_neg;
  assign is_div     = (alu_op >= 5'd15) && (alu_op <= 5'd18);
  assign div_signed = (alu_op == 5'd15) || (alu_op == 5'd17);
  assign a_neg      = div_signed && op_a[31];
  assign b_neg      = div_signed && op_b[31];

  // The stall is combinational so that upstream holds in the same cycle the
  // divide is seen. A flush or reset drops it at once.
  assign stall_ex = reset_n && !flush &&
                    (((state == IDLE) && valid_ex && is_div) || (state == BUSY));

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract if it fits.
  logic [32:0] sh, diff;
  assign sh   = {rem, quo[31]};
  assign diff = sh - {1'b0, dvs};

  // Sign correction and special cases. Overflow (-2^31 / -1) needs no special
  // handling: |A|/1 = 0x80000000 and the two signs cancel.
  logic [31:0] q_fix, r_fix, div_res;
  always_comb begin
    q_fix = neg_q ? (32'h0 - quo) : quo;
    r_fix = neg_r ? (32'h0 - rem) : rem;
    if (by_zero) begin
      q_fix = 32'hFFFF_FFFF;
      r_fix = a_orig;
    end
    div_res = want_rem ? r_fix : q_fix;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      a_orig   <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      by_zero  <= 1'b0;
      want_rem <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (valid_ex && is_div) begin
          quo      <= a_neg ? (32'h0 - op_a) : op_a;
          dvs      <= b_neg ? (32'h0 - op_b) : op_b;
          rem      <= '0;
          a_orig   <= op_a;
          neg_q    <= a_neg ^ b_neg;
          neg_r    <= a_neg;
          by_zero  <= (op_b == 32'h0);
          want_rem <= (alu_op == 5'd17) || (alu_op == 5'd18);
          cnt      <= CW'(DIV_BITS);
          state    <= BUSY;
        end
        BUSY: begin
          if (!diff[32]) begin
            rem <= diff[31:0];
            quo <= {quo[30:0], 1'b1};
          end else begin
            rem <= sh[31:0];
            quo <= {quo[30:0], 1'b0};
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // EX/MEM register. During a stall only ctrl changes, to a bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_mem    <= '0;
      rd_mem      <= '0;
      pc4_mem     <= '0;
      alu_result  <= '0;
      write_data1 <= '0;
    end else if (stall_ex) begin
      ctrl_mem <= '0;
    end else begin
      ctrl_mem    <= (valid_ex && !flush) ? ctrl_ex : 5'b0;
      rd_mem      <= rd_ex;
      pc4_mem     <= pc4_ex;
      alu_result  <= (state == DONE) ? div_res : alu_comb;
      write_data1 <= op_bf;
    end
  end
endmodule
